pipe_renderer: RTL and testbench
================================

// Module: pipe_renderer
// PURPOSE
//  Pixel-stage consumer of the 640x480 VGA scan outputs (x, y, video_on, p_tick).
//  Holds NPIPE scrolling pipe obstacles with LFSR-randomised gaps and scrolls them
//  left once per frame. Per pixel it reports whether the scan position hits a pipe,
//  and the pipe colour. Pulses score_pulse when a pipe passes the bird column.
//  Feeds the top-level colour mux alongside the bird and background layers.
// PARAMETERS
//  NPIPE      3         number of pipe columns in rotation
//  PIPE_W     52        pipe width, pixels
//  GAP_H      120       vertical opening height, pixels
//  SPACING    240       horizontal distance between pipe right edges, pixels
//  SPEED      2         scroll step per frame, pixels (1..PIPE_W)
//  BIRD_X     160       column used for scoring (> SPEED)
//  GAP_MIN    60        minimum gap top row
//  GAP_MAX    300       maximum gap top row; GAP_MAX-GAP_MIN+1 must be in [128,256]
//  COLOR      12'h0A0   pipe body RGB444
//  COLOR_EDGE 12'h060   pipe rim RGB444 (first/last 2 columns of the pipe)
//  LFSR_SEED  16'hACE1  nonzero LFSR reset value
// PORTS
//  clk_100MHz  in   1   system clock; all state on its rising edge
//  reset       in   1   asynchronous, active-high
//  p_tick      in   1   25 MHz pixel clock level, sampled as data
//  x           in   10  scan column, 0..799
//  y           in   10  scan row, 0..524
//  video_on    in   1   scan position in the 640x480 active area
//  run         in   1   game active; low = idle/attract
//  freeze      in   1   bird dead; hold pipes in place
//  pipe_on     out  1   current pixel lies on a pipe
//  rgb         out  12  pipe colour, 0 when pipe_on=0
//  frame_tick  out  1   1-cycle pulse at the start of vblank
//  score_pulse out  1   1-cycle pulse when a pipe passes BIRD_X
// BEHAVIOUR
//  Reset: pipe_on=0, rgb=0, frame_tick=0, score_pulse=0, lfsr=LFSR_SEED,
//   pr[i]=640+PIPE_W+i*SPACING (right edge, 11-bit), gap[i]=(GAP_MIN+GAP_MAX)/2.
//  pix_en: 2-flop sample of p_tick; pix_en=1 for one clk cycle on each p_tick rise.
//  frame_tick: registered; asserted one cycle after a pix_en with x==0 && y==480.
//  LFSR: 16-bit Galois, mask 16'hB400, steps every clk cycle out of reset.
//  New gap: v=lfsr[7:0]; R=GAP_MAX-GAP_MIN+1; gap=GAP_MIN+(v>=R ? v-R : v).
//  Frame update, applied on the clk cycle frame_tick is high:
//   run=0: reload reset pr/gap values (new game). No score.
//   run=1, freeze=1: hold all pr/gap values. No score.
//   run=1, freeze=0, per pipe: if pr<=SPEED, set pr=pr+NPIPE*SPACING-SPEED and
//    load a new gap (spacing stays exact). Else pr=pr-SPEED.
//   score_pulse=1 (same cycle as the update register write, 1 cycle) when any pipe
//    has old pr>BIRD_X and new pr<=BIRD_X. At most one pipe crosses per frame.
//  Pixel hit: left=pr-PIPE_W. hit = video_on && x>=left && x<pr &&
//   (y<gap || y>=gap+GAP_H). Compare at 11 bits; never wrap negative.
//  Colour: edge columns (x<left+2 or x>=pr-2) use COLOR_EDGE, else COLOR.
//   Multiple pipes: lowest index wins.
//  Latency: on a pix_en cycle, x/y/video_on are evaluated and pipe_on/rgb register
//   on that edge. Outputs are held until the next pix_en. video_on=0 gives 0/0.
//  Reset mid-frame: outputs clear immediately (async). The scan resumes normally
//   on the next pix_en after release.
// TESTING
//  1 reset high -> pipe_on=0, rgb=0, pulses 0; pr0=692, pr1=932, pr2=1172, gaps=180.
//  2 run=1, 10 frame_ticks -> pr0=672; pixel x=650,y=10 -> pipe_on=1, rgb=12'h0A0;
//    x=650,y=200 -> pipe_on=0; x=621,y=10 -> rgb=12'h060.
//  3 run=1, 266 frames -> pr0=160, score_pulse exactly once, at frame 266; no others.
//  4 continue until pr0=2 -> next frame pr0=720; new gap0 within [60,300].
//  5 freeze=1 for 5 frames -> pr/gap unchanged, no score_pulse; video_on=0 -> rgb=0.
//  6 assert reset mid-line (y=100) -> outputs 0 same cycle; after release pr0=692.

Source files
------------

// File: rtl/pipe_renderer.sv
// pipe_renderer: scrolling pipe obstacles for the 640x480 scan.
// Per-pixel pipe hit/colour, frame tick and score pulse.
//
// Ports:
//   clk_100MHz, reset (async, active-high)
//   p_tick      pixel clock level, edge-detected
//   x, y        scan position
//   video_on    active area
//   run         game active (low reloads pipes)
//   freeze      bird dead (hold pipes)
//   pipe_on     pixel is on a pipe (registered)
//   rgb         pipe colour, 0 when off
//   frame_tick  1-cycle pulse at vblank start
//   score_pulse 1-cycle pulse when a pipe passes BIRD_X
module pipe_renderer #(
  parameter int          NPIPE      = 3,
  parameter int          PIPE_W     = 52,
  parameter int          GAP_H      = 120,
  parameter int          SPACING    = 240,
  parameter int          SPEED      = 2,
  parameter int          BIRD_X     = 160,
  parameter int          GAP_MIN    = 60,
  parameter int          GAP_MAX    = 300,
  parameter logic [11:0] COLOR      = 12'h0A0,
  parameter logic [11:0] COLOR_EDGE = 12'h060,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        p_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        run,
  input  logic        freeze,
  output logic        pipe_on,
  output logic [11:0] rgb,
  output logic        frame_tick,
  output logic        score_pulse
);

  localparam logic [10:0] L_SPEED = 11'(SPEED);
  localparam logic [10:0] L_BIRD  = 11'(BIRD_X);
  localparam logic [10:0] L_WRAP  = 11'(NPIPE*SPACING - SPEED);
  localparam logic [10:0] L_PW    = 11'(PIPE_W);
  localparam logic [10:0] L_PW2   = 11'(PIPE_W - 2);
  localparam logic [10:0] L_GAPH  = 11'(GAP_H);
  localparam logic [10:0] L_GMIN  = 11'(GAP_MIN);
  localparam logic [10:0] L_GMID  = 11'((GAP_MIN + GAP_MAX) / 2);
  localparam logic [8:0]  L_R     = 9'(GAP_MAX - GAP_MIN + 1);

  logic        r_pt0, r_pt1;
  logic [15:0] r_lfsr;
  logic [10:0] r_pr  [NPIPE];
  logic [10:0] r_gap [NPIPE];

  logic        w_pix_en;
  logic [10:0] w_new_gap;
  logic [10:0] w_pr_nxt [NPIPE];
  logic        w_wrap   [NPIPE];
  logic        w_cross;
  logic        w_hit;
  logic        w_edge;
  logic [10:0] w_x, w_y;
  logic [8:0]  w_v;

  assign w_pix_en = r_pt0 & ~r_pt1;
  assign w_x = {1'b0, x};
  assign w_y = {1'b0, y};
  assign w_v = {1'b0, r_lfsr[7:0]};

  // v < 2R, so one conditional subtract is an exact modulo.
  assign w_new_gap = L_GMIN + 11'((w_v >= L_R) ? w_v - L_R : w_v);

  always_comb begin
    w_cross = 1'b0;
    for (int i = 0; i < NPIPE; i++) begin
      w_wrap[i] = (r_pr[i] <= L_SPEED);
      if (w_wrap[i])
        w_pr_nxt[i] = r_pr[i] + L_WRAP;
      else
        w_pr_nxt[i] = r_pr[i] - L_SPEED;
      if (r_pr[i] > L_BIRD && w_pr_nxt[i] <= L_BIRD)
        w_cross = 1'b1;
    end
  end

  // Left edge is pr-PIPE_W; compare as x+PIPE_W so nothing goes negative.
  always_comb begin
    w_hit  = 1'b0;
    w_edge = 1'b0;
    for (int i = NPIPE - 1; i >= 0; i--) begin
      if (w_x + L_PW >= r_pr[i] && w_x < r_pr[i] &&
          (w_y < r_gap[i] || w_y >= r_gap[i] + L_GAPH)) begin
        w_hit  = 1'b1;
        w_edge = (w_x + L_PW2 < r_pr[i]) ||
                 (w_x + 11'd2 >= r_pr[i]);
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_pt0       <= 1'b0;
      r_pt1       <= 1'b0;
      r_lfsr      <= LFSR_SEED;
      pipe_on     <= 1'b0;
      rgb         <= 12'h000;
      frame_tick  <= 1'b0;
      score_pulse <= 1'b0;
      for (int i = 0; i < NPIPE; i++) begin
        r_pr[i]  <= 11'(640 + PIPE_W + i*SPACING);
        r_gap[i] <= L_GMID;
      end
    end else begin
      r_pt0  <= p_tick;
      r_pt1  <= r_pt0;
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^
                (r_lfsr[0] ? 16'hB400 : 16'h0000);
      frame_tick  <= w_pix_en && x == 10'd0 && y == 10'd480;
      score_pulse <= 1'b0;

      if (w_pix_en) begin
        pipe_on <= video_on && w_hit;
        if (video_on && w_hit)
          rgb <= w_edge ? COLOR_EDGE : COLOR;
        else
          rgb <= 12'h000;
      end

      if (frame_tick) begin
        if (!run) begin
          for (int i = 0; i < NPIPE; i++) begin
            r_pr[i]  <= 11'(640 + PIPE_W + i*SPACING);
            r_gap[i] <= L_GMID;
          end
        end else if (!freeze) begin
          score_pulse <= w_cross;
          for (int i = 0; i < NPIPE; i++) begin
            r_pr[i] <= w_pr_nxt[i];
            if (w_wrap[i])
              r_gap[i] <= w_new_gap;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_renderer.sv
// tb_pipe_renderer: directed + random checks of pipe_renderer
// against an arithmetic reference model.
module tb_pipe_renderer;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic        p_tick;
  logic [9:0]  x, y;
  logic        video_on, run, freeze;
  logic        pipe_on;
  logic [11:0] rgb;
  logic        frame_tick, score_pulse;

  int n_chk = 0;
  int n_err = 0;
  int n_score = 0;
  int m_pr [3];
  int m_gap [3];
  bit exp_score;
  logic [15:0] m_lfsr;

  always #5 clk_100MHz = ~clk_100MHz;

  pipe_renderer dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .p_tick     (p_tick),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .run        (run),
    .freeze     (freeze),
    .pipe_on    (pipe_on),
    .rgb        (rgb),
    .frame_tick (frame_tick),
    .score_pulse(score_pulse)
  );

  always @(posedge clk_100MHz or posedge reset)
    if (reset) m_lfsr <= 16'hACE1;
    else m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_pr[k]  = 692 + k*240;
      m_gap[k] = 180;
    end
  endtask

  task automatic m_frame(logic [15:0] lf);
    int old;
    exp_score = 0;
    if (!run) m_reset();
    else if (!freeze)
      for (int k = 0; k < 3; k++) begin
        old = m_pr[k];
        if (m_pr[k] <= 2) begin
          m_pr[k]  = m_pr[k] + 720 - 2;
          m_gap[k] = 60 + (int'(lf[7:0]) % 241);
        end else m_pr[k] = m_pr[k] - 2;
        if (old > 160 && m_pr[k] <= 160) exp_score = 1;
      end
  endtask

  function automatic logic [12:0] m_pix(int xv, int yv, bit vo);
    int l;
    if (!vo) return 13'h0;
    for (int k = 0; k < 3; k++) begin
      l = m_pr[k] - 52;
      if (xv >= l && xv < m_pr[k] &&
          (yv < m_gap[k] || yv >= m_gap[k] + 120))
        return {1'b1, (xv < l + 2 || xv >= m_pr[k] - 2)
                      ? 12'h060 : 12'h0A0};
    end
    return 13'h0;
  endfunction

  task automatic pixel(int xv, int yv, bit vo);
    bit fr;
    fr = (xv == 0 && yv == 480);
    exp_score = 0;
    @(negedge clk_100MHz);
    x = 10'(xv); y = 10'(yv); video_on = vo; p_tick = 1'b1;
    @(posedge clk_100MHz);
    @(posedge clk_100MHz);
    #1;
    chk("frame_tick", 32'(frame_tick), 32'(fr));
    if (fr) m_frame(m_lfsr);
    @(negedge clk_100MHz);
    p_tick = 1'b0;
    @(posedge clk_100MHz);
    #1;
    chk("frame_tick_len", 32'(frame_tick), 0);
    chk("score_pulse", 32'(score_pulse), 32'(exp_score));
    if (score_pulse === 1'b1) n_score++;
    @(posedge clk_100MHz);
  endtask

  task automatic frame();
    pixel(0, 480, 1'b0);
  endtask

  task automatic probe(string tag, int xv, int yv, bit vo);
    logic [12:0] e;
    e = m_pix(xv, yv, vo);
    pixel(xv, yv, vo);
    #1;
    chk({tag, "_on"}, 32'(pipe_on), 32'(e[12]));
    chk({tag, "_rgb"}, 32'(rgb), 32'(e[11:0]));
  endtask

  task automatic chk_state(string tag);
    chk({tag, "_pr0"}, 32'(dut.r_pr[0]), 32'(m_pr[0]));
    chk({tag, "_pr1"}, 32'(dut.r_pr[1]), 32'(m_pr[1]));
    chk({tag, "_pr2"}, 32'(dut.r_pr[2]), 32'(m_pr[2]));
    chk({tag, "_gap0"}, 32'(dut.r_gap[0]), 32'(m_gap[0]));
    chk({tag, "_gap1"}, 32'(dut.r_gap[1]), 32'(m_gap[1]));
    chk({tag, "_gap2"}, 32'(dut.r_gap[2]), 32'(m_gap[2]));
  endtask

  task automatic rand_probes(string tag, int n);
    int k, xv, yv;
    for (int i = 0; i < n; i++) begin
      k  = int'($urandom_range(0, 2));
      xv = m_pr[k] - int'($urandom_range(0, 60));
      if (xv < 0) xv = 0;
      if (xv > 799) xv = int'($urandom_range(0, 799));
      yv = int'($urandom_range(0, 479));
      probe(tag, xv, yv, 1'($urandom_range(0, 3) != 0));
    end
  endtask

  initial begin
    int guard, yy;
    reset = 1'b1; p_tick = 1'b0; x = '0; y = '0;
    video_on = 1'b0; run = 1'b0; freeze = 1'b0;
    m_reset();
    repeat (3) @(posedge clk_100MHz);
    #1;
    chk("rst_on", 32'(pipe_on), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_ft", 32'(frame_tick), 0);
    chk("rst_sp", 32'(score_pulse), 0);
    chk_state("rst");
    @(negedge clk_100MHz);
    reset = 1'b0;

    run = 1'b1;
    repeat (10) frame();
    chk("f10_pr0", 32'(dut.r_pr[0]), 672);
    chk_state("f10");
    probe("p650_10", 650, 10, 1'b1);
    chk("p650_10_lit", 32'(rgb), 32'h0A0);
    probe("p650_200", 650, 200, 1'b1);
    chk("p650_200_lit", 32'(pipe_on), 0);
    probe("p621_10", 621, 10, 1'b1);
    chk("p621_10_lit", 32'(rgb), 32'h060);
    rand_probes("rnd_a", 10);

    repeat (255) frame();
    chk("f265_score", n_score, 0);
    frame();
    chk("f266_pr0", 32'(dut.r_pr[0]), 160);
    chk("f266_score", n_score, 1);
    chk_state("f266");

    guard = 0;
    while (m_pr[0] != 2 && guard < 400) begin
      frame();
      guard++;
    end
    chk("reach_pr2", 32'(dut.r_pr[0]), 2);
    frame();
    chk("wrap_pr0", 32'(dut.r_pr[0]), 720);
    chk("wrap_gap_rng", 32'(dut.r_gap[0] >= 60 && dut.r_gap[0] <= 300), 1);
    chk_state("wrap");
    repeat (150) frame();
    chk_state("f_more");
    chk("score_total", n_score, 2);
    rand_probes("rnd_b", 15);

    freeze = 1'b1;
    repeat (5) frame();
    chk_state("frz");
    probe("frz_vo0", m_pr[1] - 20, 5, 1'b0);
    chk("frz_vo0_rgb", 32'(rgb), 0);
    rand_probes("rnd_frz", 5);
    freeze = 1'b0;
    repeat (3) frame();
    chk_state("unfrz");

    run = 1'b0;
    frame();
    chk_state("run0");
    run = 1'b1;
    repeat (20) frame();

    yy = (100 < m_gap[0] || 100 >= m_gap[0] + 120) ? 100 : m_gap[0] + 120;
    probe("pre_rst", m_pr[0] - 20, yy, 1'b1);
    chk("pre_rst_on", 32'(pipe_on), 1);
    @(negedge clk_100MHz);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_on", 32'(pipe_on), 0);
    chk("mid_rst_rgb", 32'(rgb), 0);
    chk("mid_rst_sp", 32'(score_pulse), 0);
    m_reset();
    @(negedge clk_100MHz);
    reset = 1'b0;
    chk("post_rst_pr0", 32'(dut.r_pr[0]), 692);
    probe("post_rst", 650, 10, 1'b1);
    repeat (4) frame();
    chk_state("post_rst");
    rand_probes("rnd_c", 8);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
